id_ex_stage: RTL

ID/EX pipeline stage for the 5-stage MIPS pipeline. It registers the decode-stage control word (from the main control decoder) and the decoded operands into the EX stage. It selects the destination register and detects load-use hazards. On a hazard it inserts a bubble and tells the fetch and decode stages to hold. It sits directly downstream of the instruction decoder/control unit and upstream of the ALU/EX stage.

---
 rtl/id_ex_stage_pkg.sv | 65 ++++++
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 95 +++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage and the control decoder.
// Optional feature macro: ID_EX_HAZARD_EN (load-use detection; see hazard_detect).
package id_ex_stage_pkg;

    localparam int XLEN = 32;
    localparam int RLEN = 5;

    // ALU operation codes shared with the control decoder.
    localparam logic [4:0] ALU_ADDU = 5'd0;
    localparam logic [4:0] ALU_SUBU = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;

    // Immediate extension selects.
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HIGH = 2'd2;

    typedef struct packed {
        logic       regw;
        logic       memr;
        logic       mem2r;
        logic       memw;
        logic       branch;
        logic       jump;
        logic       bne;
        logic       alusrc;
        logic [4:0] aluctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Everything the EX stage sees from this register bank.
    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [RLEN-1:0] rs;
        logic [RLEN-1:0] rt;
        logic [RLEN-1:0] shamt;
        logic [RLEN-1:0] wreg;
    } ex_word_t;

    localparam ex_word_t EX_BUBBLE = '{1'b0, CTRL_BUBBLE, 32'd0, 32'd0, 32'd0, 32'd0,
                                       5'd0, 5'd0, 5'd0, 5'd0};

    // R-type writes rd, I-type writes rt.
    function automatic logic [RLEN-1:0] dest_reg(input logic regdst,
                                                 input logic [RLEN-1:0] rt,
                                                 input logic [RLEN-1:0] rd);
        return regdst ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and EX-side signal bundle of the ID/EX stage.
// master: decoder/pipeline glue driving id_*, flush, hold; slave: the stage itself.
interface id_ex_stage_if;

    logic        id_valid;
    logic        id_regdst;
    logic        id_branch;
    logic        id_memr;
    logic        id_mem2r;
    logic        id_memw;
    logic        id_regw;
    logic        id_alusrc;
    logic        id_jump;
    logic        id_bne;
    logic [1:0]  id_extop;
    logic [4:0]  id_aluctrl;
    logic [31:0] id_pc;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic        flush;
    logic        hold;

    logic        stall;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_memr;
    logic        ex_mem2r;
    logic        ex_memw;
    logic        ex_regw;
    logic        ex_alusrc;
    logic        ex_jump;
    logic        ex_bne;
    logic [4:0]  ex_aluctrl;
    logic [31:0] ex_pc;
    logic [31:0] ex_rdata1;
    logic [31:0] ex_rdata2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_wreg;

    modport master (
        output id_valid, id_regdst, id_branch, id_memr, id_mem2r, id_memw, id_regw,
               id_alusrc, id_jump, id_bne, id_extop, id_aluctrl, id_pc, id_rdata1,
               id_rdata2, id_imm, id_rs, id_rt, id_rd, id_shamt, flush, hold,
        input  stall, ex_valid, ex_branch, ex_memr, ex_mem2r, ex_memw, ex_regw,
               ex_alusrc, ex_jump, ex_bne, ex_aluctrl, ex_pc, ex_rdata1, ex_rdata2,
               ex_imm, ex_rs, ex_rt, ex_shamt, ex_wreg
    );

    modport slave (
        input  id_valid, id_regdst, id_branch, id_memr, id_mem2r, id_memw, id_regw,
               id_alusrc, id_jump, id_bne, id_extop, id_aluctrl, id_pc, id_rdata1,
               id_rdata2, id_imm, id_rs, id_rt, id_rd, id_shamt, flush, hold,
        output stall, ex_valid, ex_branch, ex_memr, ex_mem2r, ex_memw, ex_regw,
               ex_alusrc, ex_jump, ex_bne, ex_aluctrl, ex_pc, ex_rdata1, ex_rdata2,
               ex_imm, ex_rs, ex_rt, ex_shamt, ex_wreg
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the decoding
// instruction. Purely combinational. Active only with ID_EX_HAZARD_EN defined;
// otherwise lu is tied low and software must pad each load with a nop.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_memr,
    input  logic [4:0] ex_wreg,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_alusrc,
    input  logic       id_memw,
    output logic       lu
);

`ifdef ID_EX_HAZARD_EN
    logic rs_hit;
    logic rt_hit;

    // rt is only a source operand for register-register ops and for stores.
    assign rs_hit = (ex_wreg == id_rs);
    assign rt_hit = (ex_wreg == id_rt) && (!id_alusrc || id_memw);
    assign lu     = ex_valid && ex_memr && (ex_wreg != 5'd0) && id_valid && (rs_hit || rt_hit);
`else
    // Inputs are still referenced so the port list is identical in both builds;
    // the AND with zero folds the whole expression to a constant.
    assign lu = 1'b0 & (^{ex_valid, ex_memr, ex_wreg, id_valid, id_rs, id_rt,
                          id_alusrc, id_memw});
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion and load-use stall.
// Priority per cycle: rst > hold > flush > load-use > normal load.
// Optional feature macro: ID_EX_HAZARD_EN (enables load-use detection).
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    ex_word_t ex_q;
    ex_word_t ex_d;
    ex_word_t id_word;
    logic     lu;

    hazard_detect u_hazard (
        .ex_valid  (ex_q.valid),
        .ex_memr   (ex_q.ctrl.memr),
        .ex_wreg   (ex_q.wreg),
        .id_valid  (bus.id_valid),
        .id_rs     (bus.id_rs),
        .id_rt     (bus.id_rt),
        .id_alusrc (bus.id_alusrc),
        .id_memw   (bus.id_memw),
        .lu        (lu)
    );

    // Assemble the decode-side fields into the word EX would receive.
    always_comb begin
        id_word              = EX_BUBBLE;
        id_word.valid        = 1'b1;
        id_word.ctrl.regw    = bus.id_regw;
        id_word.ctrl.memr    = bus.id_memr;
        id_word.ctrl.mem2r   = bus.id_mem2r;
        id_word.ctrl.memw    = bus.id_memw;
        id_word.ctrl.branch  = bus.id_branch;
        id_word.ctrl.jump    = bus.id_jump;
        id_word.ctrl.bne     = bus.id_bne;
        id_word.ctrl.alusrc  = bus.id_alusrc;
        id_word.ctrl.aluctrl = bus.id_aluctrl;
        id_word.pc           = bus.id_pc;
        id_word.rdata1       = bus.id_rdata1;
        id_word.rdata2       = bus.id_rdata2;
        id_word.imm          = bus.id_imm;
        id_word.rs           = bus.id_rs;
        id_word.rt           = bus.id_rt;
        id_word.shamt        = bus.id_shamt;
        id_word.wreg         = dest_reg(bus.id_regdst, bus.id_rt, bus.id_rd);
    end

    // Priority mux: hold freezes (and masks flush), flush/load-use/empty decode load a bubble.
    always_comb begin
        ex_d = ex_q;
        if (bus.hold) begin
            ex_d = ex_q;
        end else if (bus.flush || lu || !bus.id_valid) begin
            ex_d = EX_BUBBLE;
        end else begin
            ex_d = id_word;
        end
    end

    // EX register bank; reset loads a bubble so no stall or hold survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    // A flush squashes the decoding instruction, so its hazard no longer matters.
    assign bus.stall      = !rst && (bus.hold || (lu && !bus.flush));

    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_branch  = ex_q.ctrl.branch;
    assign bus.ex_memr    = ex_q.ctrl.memr;
    assign bus.ex_mem2r   = ex_q.ctrl.mem2r;
    assign bus.ex_memw    = ex_q.ctrl.memw;
    assign bus.ex_regw    = ex_q.ctrl.regw;
    assign bus.ex_alusrc  = ex_q.ctrl.alusrc;
    assign bus.ex_jump    = ex_q.ctrl.jump;
    assign bus.ex_bne     = ex_q.ctrl.bne;
    assign bus.ex_aluctrl = ex_q.ctrl.aluctrl;
    assign bus.ex_pc      = ex_q.pc;
    assign bus.ex_rdata1  = ex_q.rdata1;
    assign bus.ex_rdata2  = ex_q.rdata2;
    assign bus.ex_imm     = ex_q.imm;
    assign bus.ex_rs      = ex_q.rs;
    assign bus.ex_rt      = ex_q.rt;
    assign bus.ex_shamt   = ex_q.shamt;
    assign bus.ex_wreg    = ex_q.wreg;

endmodule
